// File: rtl/round_timer_compare_pkg.sv
// Shared definitions for the round timer / target comparator.
//   state_t     : FSM state encoding (IDLE, RUN, EXPIRED)
//   TIME_W      : width of the round-time countdown
//   NUM_W       : width of target / switch values
//   LFSR_TAPS   : feedback tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   level_mask  : target mask for a given difficulty level
package round_timer_compare_pkg;

  localparam int TIME_W = 5;
  localparam int NUM_W  = 8;

  localparam logic [NUM_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // (1 << (lvl+1)) - 1, computed in 9 bits so lvl=7 yields 8'hFF.
  function automatic logic [NUM_W-1:0] level_mask(input logic [2:0] lvl);
    logic [NUM_W:0] m;
    m = (9'd1 << ({1'b0, lvl} + 4'd1)) - 9'd1;
    return m[NUM_W-1:0];
  endfunction

endpackage

// File: rtl/round_timer_compare_lfsr8.sv
// 8-bit Fibonacci LFSR, free-running every clock.
//   clk  in   system clock
//   rst  in   asynchronous active-high reset, loads SEED
//   q    out  current LFSR state (never zero for a non-zero SEED)
module lfsr8
  import round_timer_compare_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[6:0], feedback};
  end

endmodule

// File: rtl/round_timer_compare.sv
// Target generator, switch comparator and per-round countdown.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   set_f      in   1-cycle load/abort strobe
//   set_v      in   round time in ticks; 0 with set_f aborts the round
//   level      in   difficulty; level[2:0] selects target width
//   sw         in   player switch value
//   cmp_r      out  registered match of masked sw against target (RUN only)
//   end_f      out  round time expired, held until set_f or rst
//   target     out  current masked target
//   time_left  out  remaining ticks
module round_timer_compare
  import round_timer_compare_pkg::*;
#(
  parameter int         TICK_DIV  = 50_000_000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_f,
  input  logic [TIME_W-1:0] set_v,
  input  logic [7:0]        level,
  input  logic [NUM_W-1:0]  sw,
  output logic              cmp_r,
  output logic              end_f,
  output logic [NUM_W-1:0]  target,
  output logic [TIME_W-1:0] time_left
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t              state_reg, state_next;
  logic [PRESC_W-1:0]  presc_reg, presc_next;
  logic [TIME_W-1:0]   time_left_reg, time_left_next;
  logic [NUM_W-1:0]    target_reg, target_next;
  logic [NUM_W-1:0]    mask_reg, mask_next;
  logic                end_f_reg, end_f_next;
  logic                cmp_r_reg, cmp_r_next;
  logic [NUM_W-1:0]    lfsr_q;
  logic                unused_level;

  assign unused_level = ^level[7:3];

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    time_left_next = time_left_reg;
    target_next    = target_reg;
    mask_next      = mask_reg;
    end_f_next     = end_f_reg;

    if (set_f) begin
      // A strobe always wins over a pending tick wrap.
      end_f_next = 1'b0;
      if (set_v != '0) begin
        mask_next      = level_mask(level[2:0]);
        target_next    = lfsr_q & level_mask(level[2:0]);
        time_left_next = set_v;
        presc_next     = '0;
        state_next     = RUN;
      end else begin
        target_next    = '0;
        time_left_next = '0;
        state_next     = IDLE;
      end
    end else if (state_reg == RUN) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        if (time_left_reg == TIME_W'(1)) begin
          time_left_next = '0;
          end_f_next     = 1'b1;
          state_next     = EXPIRED;
        end else begin
          time_left_next = time_left_reg - TIME_W'(1);
        end
      end else begin
        presc_next = presc_reg + PRESC_W'(1);
      end
    end

    // Requiring RUN on both sides of the edge keeps cmp_r low in the cycle
    // after an abort or expiry, not just once the FSM has settled there.
    cmp_r_next = (state_reg == RUN) && (state_next == RUN) &&
                 ((sw & mask_reg) == target_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      time_left_reg <= '0;
      target_reg    <= '0;
      mask_reg      <= '0;
      end_f_reg     <= 1'b0;
      cmp_r_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      time_left_reg <= time_left_next;
      target_reg    <= target_next;
      mask_reg      <= mask_next;
      end_f_reg     <= end_f_next;
      cmp_r_reg     <= cmp_r_next;
    end
  end

  assign cmp_r     = cmp_r_reg;
  assign end_f     = end_f_reg;
  assign target    = target_reg;
  assign time_left = time_left_reg;

endmodule

// File: tb/tb_round_timer_compare.sv
module tb_round_timer_compare;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_f = 1'b0;
  logic [4:0] set_v = '0;
  logic [7:0] level = '0;
  logic [7:0] sw = '0;
  logic       cmp_r;
  logic       end_f;
  logic [7:0] target;
  logic [4:0] time_left;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    int         sel;   // 0 cmp_r, 1 end_f, 2 target, 3 time_left
    logic [7:0] exp;
  } item_t;

  item_t sb[$];

  logic [7:0] lfsr_m;
  logic [7:0] exp_t;
  logic [7:0] exp_t2;
  bit         found;

  round_timer_compare #(.TICK_DIV(4), .LFSR_SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_f     (set_f),
    .set_v     (set_v),
    .level     (level),
    .sw        (sw),
    .cmp_r     (cmp_r),
    .end_f     (end_f),
    .target    (target),
    .time_left (time_left)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= lfsr_step(lfsr_m);
  end

  function automatic logic [7:0] bmask(input int l);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i <= l; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      0:       return {7'b0, cmp_r};
      1:       return {7'b0, end_f};
      2:       return target;
      default: return {3'b0, time_left};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [7:0] exp);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check();
    item_t it;
    logic [7:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o = obs(it.sel);
      total++;
      assert (o === it.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
      end
      $display("check %s observed=%0h expected=%0h", it.tag, o, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    push("rst_cmp", 0, 8'h00);
    push("rst_end", 1, 8'h00);
    push("rst_tgt", 2, 8'h00);
    push("rst_time", 3, 8'h00);
    check();
    rst = 1'b0;

    // Load right after release: LFSR still holds its seed
    set_f = 1'b1; set_v = 5'd3; level = 8'd7;
    push("t2_load_tgt", 2, 8'hA5);
    push("t2_load_time", 3, 8'd3);
    push("t2_load_end", 1, 8'd0);
    tick();
    set_f = 1'b0;
    check();

    // Countdown, comparator, mid-round level change ignored
    for (int k = 1; k <= 12; k++) begin
      sw = (k % 2 == 1) ? 8'hA5 : 8'hA4;
      if (k == 5) level = 8'd0;
      push("t2_time", 3, (k < 12) ? 8'(3 - k / 4) : 8'd0);
      push("t2_end", 1, (k == 12) ? 8'd1 : 8'd0);
      push("t2_cmp", 0, (k < 12 && k % 2 == 1) ? 8'd1 : 8'd0);
      push("t2_tgt", 2, 8'hA5);
      tick();
      check();
    end

    // EXPIRED holds end_f and reveals target
    sw = 8'hA5;
    repeat (2) tick();
    push("exp_end", 1, 8'd1);
    push("exp_time", 3, 8'd0);
    push("exp_tgt", 2, 8'hA5);
    push("exp_cmp", 0, 8'd0);
    check();

    // Abort in EXPIRED clears end_f
    set_f = 1'b1; set_v = 5'd0;
    push("abx_end", 1, 8'd0);
    push("abx_tgt", 2, 8'd0);
    push("abx_time", 3, 8'd0);
    tick();
    set_f = 1'b0;
    check();

    // Level 0 load with target 0: wait (bounded) for an even LFSR value
    level = 8'd0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (lfsr_m[0] == 1'b0) found = 1'b1;
      else tick();
    end
    if (!found) begin
      total++;
      bad++;
      $error("FAIL t4_wait observed=timeout expected=even_lfsr");
    end
    exp_t = lfsr_m & bmask(0);
    set_f = 1'b1; set_v = 5'd2;
    push("t4_tgt", 2, exp_t);
    push("t4_time", 3, 8'd2);
    tick();
    set_f = 1'b0;
    check();
    sw = 8'hFE;
    push("t4_cmp_masked", 0, (exp_t == 8'h00) ? 8'd1 : 8'd0);
    tick();
    check();
    sw = 8'hFF;
    push("t4_cmp_ff", 0, (exp_t == 8'h01) ? 8'd1 : 8'd0);
    tick();
    check();
    repeat (5) tick();
    push("t5_pre_time", 3, 8'd1);
    push("t5_pre_end", 1, 8'd0);
    check();

    // Reload on the final tick-wrap cycle: tick discarded, no end_f
    set_f = 1'b1; set_v = 5'd5; level = 8'd3;
    exp_t2 = lfsr_m & bmask(3);
    push("t5_time", 3, 8'd5);
    push("t5_end", 1, 8'd0);
    push("t5_tgt", 2, exp_t2);
    tick();
    set_f = 1'b0;
    check();
    repeat (3) tick();
    push("t5_hold_time", 3, 8'd5);
    check();
    tick();
    push("t5_dec_time", 3, 8'd4);
    check();

    // Abort during RUN
    sw = exp_t2;
    push("t6_cmp_hit", 0, 8'd1);
    tick();
    check();
    set_f = 1'b1; set_v = 5'd0;
    push("t6_cmp", 0, 8'd0);
    push("t6_time", 3, 8'd0);
    push("t6_tgt", 2, 8'd0);
    push("t6_end", 1, 8'd0);
    tick();
    set_f = 1'b0;
    check();
    push("t6_idle_cmp", 0, 8'd0);
    tick();
    check();

    // Asynchronous reset mid-round
    set_f = 1'b1; set_v = 5'd7; level = 8'd7;
    tick();
    set_f = 1'b0;
    repeat (5) tick();
    push("t1_pre_time", 3, 8'd6);
    check();
    sw = target;
    #2;
    rst = 1'b1;
    #1;
    push("t1_cmp", 0, 8'd0);
    push("t1_end", 1, 8'd0);
    push("t1_tgt", 2, 8'd0);
    push("t1_time", 3, 8'd0);
    check();
    tick();
    rst = 1'b0;
    set_f = 1'b1; set_v = 5'd3; level = 8'd7;
    push("t1_seed_tgt", 2, 8'hA5);
    push("t1_seed_time", 3, 8'd3);
    tick();
    set_f = 1'b0;
    check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
